alu_chain_ctrl: RTL
===================

Name: alu_chain_ctrl

Overview:
- Initiator for the team's registered 16-bit ALU. It accepts one wide operation of WORDS x 16 bits on a valid/ready request port.
- It issues the operation to the ALU one 16-bit slice per cycle, least-significant slice first, and chains carry/borrow from each slice into the next.
- It assembles the slice results and returns the wide result on a valid/ready response port.
- It sits between the datapath command source and the ALU; its alu_* ports connect directly to the ALU's op_code/a_in/b_in/cin/y_out/cout.

Parameters:
- WORDS, 4, number of 16-bit slices per operation (>=2); wide width W = 16*WORDS.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset. Also resets the attached ALU.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready. High only in IDLE.
- req_op  in  3  000 PASS, 001 ADD, 010 ADDC, 011 SUB, 100 SUBB, 101 OR, 110 XOR, 111 AND.
- req_cin  in  1  carry-in (ADDC) or borrow-in (SUBB) for slice 0. Ignored for other ops.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_y  out  W  result.
- rsp_cout  out  1  final carry/borrow. 0 for PASS/logic ops.
- busy  out  1  high in any state other than IDLE.
- alu_op_code  out  4  ALU opcode (registered).
- alu_a  out  16  ALU a_in slice (registered).
- alu_b  out  16  ALU b_in slice (registered).
- alu_cin  out  1  ALU cin.
- alu_y  in  16  ALU y_out. Valid one edge after issue.
- alu_cout  in  1  ALU cout.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - rsp_valid=0, rsp_y=0, rsp_cout=0, busy=0.
  - alu_op_code=0000, alu_a=alu_b=0, alu_cin=0.
  - req_ready=1 once reset is held.
- Reset mid-operation discards all partial results. No response is produced for the aborted request.
- States: IDLE -> ISSUE(k=0..WORDS-1) -> DRAIN -> RESP -> IDLE.
- IDLE:
  - Accept when req_valid & req_ready at an edge.
  - Latch op, cin, A and B.
  - Drive slice 0 on alu_* and enter ISSUE k=0.
- ISSUE k:
  - alu_a/alu_b hold bits [16k+15:16k].
  - At the edge ending this state, capture alu_y into rsp_y slice k-1 (when k>=1).
  - Advance k. After k=WORDS-1, go to DRAIN.
- DRAIN:
  - Capture alu_y into slice WORDS-1 and alu_cout into rsp_cout (0 for PASS/logic).
  - Go to RESP.
  - alu_* return to idle values (0000/0/0/0).
- RESP:
  - rsp_valid=1. rsp_y and rsp_cout are held stable.
  - On rsp_valid & rsp_ready, go to IDLE with rsp_valid=0.
  - rsp_y keeps its last value until overwritten.
- Opcode mapping, slice 0:
  - PASS 0000, ADD 0001, ADDC 0010, SUB 0011, SUBB 0100, OR 1000, XOR 1001, AND 1010.
- Opcode mapping, slices k>=1:
  - ADD/ADDC use 0010; SUB/SUBB use 0100.
  - Other ops repeat their slice-0 code.
- alu_cin:
  - Slice 0: req_cin (latched) for ADDC/SUBB, else 0.
  - Slices k>=1 of arithmetic ops: combinational from alu_cout, which is the previous slice's registered carry/borrow (cout=1 means borrow for SUB).
  - Logic/PASS: 0.
- Latency: rsp_valid rises WORDS+1 edges after the accepting edge (5 for WORDS=4).
- Throughput: one request per WORDS+3 cycles minimum.
- Only one request is outstanding. A req_valid held during busy is not accepted and is not lost (req_ready=0).
- rsp_ready held low in RESP: stay in RESP indefinitely with outputs unchanged.
- Width rule: arithmetic is modulo 2^W. rsp_cout is the carry/borrow out of bit W-1.

Test Plan:
- ADD, A=0x0000_0000_0000_FFFF, B=0x1 -> rsp_y=0x0000_0000_0001_0000, rsp_cout=0. alu_op_code sequence 0001,0010,0010,0010. rsp_valid exactly 5 edges after accept.
- ADD, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> rsp_y=0, rsp_cout=1. alu_cin=1 on slices 1..3.
- SUB, A=0, B=1 -> rsp_y=0xFFFF_FFFF_FFFF_FFFF, rsp_cout=1, codes 0011,0100,0100,0100. SUBB with req_cin=1, A=0x10, B=0x5 -> rsp_y=0xA, cout=0. ADDC with req_cin=1, A=B=0 -> rsp_y=0x1.
- XOR, A=0x1234_5678_9ABC_DEF0, B=0xFFFF_0000_FFFF_0000 -> rsp_y=0xEDCB_5678_6543_DEF0, rsp_cout=0. alu_cin=0 throughout.
- Hold rsp_ready=0 for 3 cycles in RESP -> rsp_valid and rsp_y stable. Keep req_valid high throughout -> req_ready=0 and the second request is accepted only on the cycle after the response handshake. Its result must be correct.
- Assert reset_n=0 while in ISSUE k=2 -> immediately rsp_valid=0, busy=0, alu_op_code=0000. After release, an ADD 1+1 returns rsp_y=0x2 with no stale slices.

Source files
------------

// File: rtl/alu_chain_ctrl.sv
`timescale 1ns/1ps
// Wide-operation initiator for the registered 16-bit ALU: issues WORDS slices
// LSB first, chains carry/borrow through alu_cout, and returns the assembled result.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both
// high. req_ready is high only in IDLE. rsp_valid is high only in RESP, and rsp_y and
// rsp_cout stay stable until rsp_ready is seen.
module alu_chain_ctrl #(
  parameter int WORDS = 4,
  localparam int W = 16 * WORDS,
  localparam int KW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic          req_cin,
  input  logic [W-1:0]  req_a,
  input  logic [W-1:0]  req_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_y,
  output logic          rsp_cout,
  output logic          busy,
  output logic [3:0]    alu_op_code,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  output logic          alu_cin,
  input  logic [15:0]   alu_y,
  input  logic          alu_cout,
  output logic [1:0]    dbg_state,
  output logic [KW-1:0] dbg_slice
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDC = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBB = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  state_t          state_q;
  state_t          state_d;
  logic [KW-1:0]   k_q;
  logic [2:0]      op_q;
  logic            cin_q;
  logic [W-17:0]   a_sh;
  logic [W-17:0]   b_sh;
  logic            accept;
  logic            last_slice;
  logic            arith_q;
  logic            cin_op_q;

  // Upper slices of ADD/SUB switch to the carry/borrow-consuming ALU opcode.
  function automatic logic [3:0] slice_code(input logic [2:0] op, input logic first);
    logic [3:0] code;
    code = 4'b0000;
    case (op)
      OP_PASS: code = 4'b0000;
      OP_ADD:  code = first ? 4'b0001 : 4'b0010;
      OP_ADDC: code = 4'b0010;
      OP_SUB:  code = first ? 4'b0011 : 4'b0100;
      OP_SUBB: code = 4'b0100;
      OP_OR:   code = 4'b1000;
      OP_XOR:  code = 4'b1001;
      OP_AND:  code = 4'b1010;
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  assign arith_q    = (op_q == OP_ADD) || (op_q == OP_ADDC) ||
                      (op_q == OP_SUB) || (op_q == OP_SUBB);
  assign cin_op_q   = (op_q == OP_ADDC) || (op_q == OP_SUBB);
  assign last_slice = (k_q == KW'(WORDS - 1));
  assign dbg_state  = state_q;
  assign dbg_slice  = k_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    rsp_valid = (state_q == S_RESP);
    accept    = req_valid && (state_q == S_IDLE);
    alu_cin   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Slice 0 takes the latched carry-in; later slices take the ALU's own carry out.
        if (k_q == '0) alu_cin = cin_op_q && cin_q;
        else           alu_cin = arith_q && alu_cout;
        if (last_slice) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q         <= '0;
      op_q        <= OP_PASS;
      cin_q       <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      alu_op_code <= 4'b0000;
      alu_a       <= 16'h0000;
      alu_b       <= 16'h0000;
      rsp_y       <= '0;
      rsp_cout    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q        <= req_op;
            cin_q       <= req_cin;
            k_q         <= '0;
            alu_op_code <= slice_code(req_op, 1'b1);
            alu_a       <= req_a[15:0];
            alu_b       <= req_b[15:0];
            a_sh        <= req_a[W-1:16];
            b_sh        <= req_b[W-1:16];
          end
        end
        S_ISSUE: begin
          // alu_y now holds the result of the slice issued one edge earlier.
          for (int i = 0; i < WORDS - 1; i++) begin
            if (k_q == KW'(i + 1)) rsp_y[16*i +: 16] <= alu_y;
          end
          if (last_slice) begin
            alu_op_code <= 4'b0000;
            alu_a       <= 16'h0000;
            alu_b       <= 16'h0000;
          end else begin
            k_q         <= k_q + KW'(1);
            alu_op_code <= slice_code(op_q, 1'b0);
            alu_a       <= a_sh[15:0];
            alu_b       <= b_sh[15:0];
            a_sh        <= a_sh >> 16;
            b_sh        <= b_sh >> 16;
          end
        end
        S_DRAIN: begin
          rsp_y[W-1 -: 16] <= alu_y;
          rsp_cout         <= arith_q && alu_cout;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
